// File: rtl/strip_frame_rx.sv
// rtl/strip_frame_rx.sv - LED-strip clock/data frame receiver with pixel strobe output
// Optional: define RX_ERR_CNT_EN to add the saturating err_count output.
module strip_frame_rx #(
  parameter int NUM_LEDS   = 64,
  parameter int IDX_W      = 6,
  parameter int TIMEOUT    = 4000,
  parameter int SYNC_ZEROS = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             strip_clk,
  input  logic             strip_data,
  output logic             pix_valid,
  output logic [IDX_W-1:0] pix_index,
  output logic [4:0]       pix_bright,
  output logic [7:0]       pix_b,
  output logic [7:0]       pix_g,
  output logic [7:0]       pix_r,
  output logic             frame_done,
  output logic             frame_err,
`ifdef RX_ERR_CNT_EN
  output logic [7:0]       err_count,
`endif
  output logic             busy
);

  localparam int ZW = $clog2(SYNC_ZEROS + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [ZW-1:0]    ZERO_MAX = ZW'(SYNC_ZEROS);
  localparam logic [TW-1:0]    IDLE_MAX = TW'(TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_LED = IDX_W'(NUM_LEDS - 1);

  typedef enum logic [1:0] {HUNT, SYNC, LED, TAIL} state_t;

  logic clk_s1, clk_s2, clk_d, dat_s1, dat_s2;
  logic bit_stb, bit_val;

  state_t           state, state_n;
  logic [ZW-1:0]    zero_cnt, zero_n, zero_inc;
  logic [4:0]       bit_cnt, bit_n;
  logic [31:0]      word, word_n, word_full;
  logic [IDX_W-1:0] led_cnt, led_n;
  logic [TW-1:0]    idle_cnt, idle_n;
  logic             pix_valid_n, frame_done_n, frame_err_n;
  logic [IDX_W-1:0] pix_index_n;
  logic [4:0]       pix_bright_n;
  logic [7:0]       pix_b_n, pix_g_n, pix_r_n;

  // Synchronize strip inputs and turn each strip-clock falling edge into a one-cycle bit strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1  <= 1'b0;
      clk_s2  <= 1'b0;
      clk_d   <= 1'b0;
      dat_s1  <= 1'b0;
      dat_s2  <= 1'b0;
      bit_stb <= 1'b0;
      bit_val <= 1'b0;
    end else begin
      clk_s1  <= strip_clk;
      clk_s2  <= clk_s1;
      clk_d   <= clk_s2;
      dat_s1  <= strip_data;
      dat_s2  <= dat_s1;
      bit_stb <= clk_d & ~clk_s2;
      bit_val <= dat_s2;
    end
  end

  assign zero_inc  = (zero_cnt == ZERO_MAX) ? zero_cnt : zero_cnt + 1'b1;
  assign word_full = {word[30:0], bit_val};
  assign busy      = (state != HUNT);

  // Frame decoder: next state, counters and registered pixel outputs
  always_comb begin
    state_n      = state;
    zero_n       = zero_cnt;
    bit_n        = bit_cnt;
    word_n       = word;
    led_n        = led_cnt;
    idle_n       = (idle_cnt == IDLE_MAX) ? idle_cnt : idle_cnt + 1'b1;
    pix_valid_n  = 1'b0;
    frame_done_n = 1'b0;
    frame_err_n  = 1'b0;
    pix_index_n  = pix_index;
    pix_bright_n = pix_bright;
    pix_b_n      = pix_b;
    pix_g_n      = pix_g;
    pix_r_n      = pix_r;
    if (bit_stb) begin
      idle_n = '0;
      case (state)
        HUNT, TAIL: begin
          if (bit_val) begin
            zero_n = '0;
          end else if (zero_inc == ZERO_MAX) begin
            zero_n  = '0;
            state_n = SYNC;
          end else begin
            zero_n = zero_inc;
          end
        end
        SYNC: begin
          // First 1 after the start frame is bit 31 of LED word 0
          if (bit_val) begin
            state_n = LED;
            word_n  = 32'd1;
            bit_n   = 5'd1;
            led_n   = '0;
          end
        end
        default: begin
          word_n = word_full;
          if (bit_cnt == 5'd31) begin
            bit_n = 5'd0;
            if (word_full[31:29] == 3'b111) begin
              pix_valid_n  = 1'b1;
              pix_index_n  = led_cnt;
              pix_bright_n = word_full[28:24];
              pix_b_n      = word_full[23:16];
              pix_g_n      = word_full[15:8];
              pix_r_n      = word_full[7:0];
              if (led_cnt == LAST_LED) begin
                frame_done_n = 1'b1;
                state_n      = TAIL;
                zero_n       = '0;
                led_n        = '0;
              end else begin
                led_n = led_cnt + 1'b1;
              end
            end else begin
              frame_err_n = 1'b1;
              state_n     = HUNT;
              zero_n      = '0;
              led_n       = '0;
            end
          end else begin
            bit_n = bit_cnt + 1'b1;
          end
        end
      endcase
    end else if (idle_cnt == IDLE_MAX && state != HUNT) begin
      // Strip clock stalled: abandon the frame, flag it only if a word was in progress
      frame_err_n = (state == LED) && (bit_cnt != 5'd0 || led_cnt != '0);
      state_n     = HUNT;
      zero_n      = '0;
      bit_n       = 5'd0;
      led_n       = '0;
    end
  end

  // Decoder state and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= HUNT;
      zero_cnt   <= '0;
      bit_cnt    <= 5'd0;
      word       <= 32'd0;
      led_cnt    <= '0;
      idle_cnt   <= '0;
      pix_valid  <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      pix_index  <= '0;
      pix_bright <= 5'd0;
      pix_b      <= 8'd0;
      pix_g      <= 8'd0;
      pix_r      <= 8'd0;
    end else begin
      state      <= state_n;
      zero_cnt   <= zero_n;
      bit_cnt    <= bit_n;
      word       <= word_n;
      led_cnt    <= led_n;
      idle_cnt   <= idle_n;
      pix_valid  <= pix_valid_n;
      frame_done <= frame_done_n;
      frame_err  <= frame_err_n;
      pix_index  <= pix_index_n;
      pix_bright <= pix_bright_n;
      pix_b      <= pix_b_n;
      pix_g      <= pix_g_n;
      pix_r      <= pix_r_n;
    end
  end

`ifdef RX_ERR_CNT_EN
  // Saturating count of frame_err pulses since reset
  always_ff @(posedge clk) begin
    if (reset) begin
      err_count <= 8'd0;
    end else if (frame_err && err_count != 8'hFF) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_strip_frame_rx.sv
// tb/tb_strip_frame_rx.sv - directed scoreboard bench for strip_frame_rx
module tb_strip_frame_rx;

  localparam int TIMEOUT = 4000;

  logic       clk = 1'b0;
  logic       reset;
  logic       strip_clk;
  logic       strip_data;
  logic       pix_valid;
  logic [5:0] pix_index;
  logic [4:0] pix_bright;
  logic [7:0] pix_b, pix_g, pix_r;
  logic       frame_done, frame_err, busy;
`ifdef RX_ERR_CNT_EN
  logic [7:0] err_count;
`endif

  typedef struct packed {
    logic [5:0] idx;
    logic [4:0] br;
    logic [7:0] b;
    logic [7:0] g;
    logic [7:0] r;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   pix_seen = 0;
  int   done_cnt = 0;
  int   err_cnt = 0;

  always #5 clk = ~clk;

  strip_frame_rx dut (
    .clk        (clk),
    .reset      (reset),
    .strip_clk  (strip_clk),
    .strip_data (strip_data),
    .pix_valid  (pix_valid),
    .pix_index  (pix_index),
    .pix_bright (pix_bright),
    .pix_b      (pix_b),
    .pix_g      (pix_g),
    .pix_r      (pix_r),
    .frame_done (frame_done),
    .frame_err  (frame_err),
`ifdef RX_ERR_CNT_EN
    .err_count  (err_count),
`endif
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    strip_data = b;
    strip_clk  = 1'b1;
    repeat (3) @(negedge clk);
    strip_clk  = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_zeros(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b0);
  endtask

  task automatic send_bits(input logic [31:0] w, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) send_bit(w[i]);
  endtask

  task automatic push_exp(input int idx, input logic [4:0] br, input logic [7:0] b,
                          input logic [7:0] g, input logic [7:0] r);
    exp_t e;
    e.idx = 6'(idx);
    e.br  = br;
    e.b   = b;
    e.g   = g;
    e.r   = r;
    exp_q.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(pix_valid), 32'd0);
    check({tag, "_done"}, 32'(frame_done), 32'd0);
    check({tag, "_err"}, 32'(frame_err), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_index"}, 32'(pix_index), 32'd0);
    check({tag, "_bright"}, 32'(pix_bright), 32'd0);
    check({tag, "_bgr"}, {8'd0, pix_b, pix_g, pix_r}, 32'd0);
`ifdef RX_ERR_CNT_EN
    check({tag, "_err_count"}, 32'(err_count), 32'd0);
`endif
  endtask

  // Scoreboard: every pixel strobe must match the oldest expected pixel
  always @(negedge clk) begin
    if (!reset) begin
      if (pix_valid) begin
        exp_t e;
        pix_seen++;
        total++;
        assert (exp_q.size() != 0) else begin
          bad++;
          $error("FAIL unexpected_pix observed index=%0d expected no strobe", pix_index);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("pix_index", 32'(pix_index), 32'(e.idx));
          check("pix_bright", 32'(pix_bright), 32'(e.br));
          check("pix_b", 32'(pix_b), 32'(e.b));
          check("pix_g", 32'(pix_g), 32'(e.g));
          check("pix_r", 32'(pix_r), 32'(e.r));
        end
      end
      if (frame_done) begin
        done_cnt++;
        check("done_with_valid", 32'(pix_valid), 32'd1);
        check("done_index", 32'(pix_index), 32'd63);
      end
      if (frame_err) err_cnt++;
    end
  end

  initial begin
    reset      = 1'b1;
    strip_clk  = 1'b0;
    strip_data = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;

    // Nominal frame
    send_zeros(32);
    for (int i = 0; i < 64; i++) begin
      push_exp(i, 5'h10, 8'h0F, 8'h00, 8'h00);
      send_bits(32'hF00F0000, 31, 0);
    end
    send_zeros(64);
    check("nom_done", 32'(done_cnt), 32'd1);
    check("nom_pix", 32'(pix_seen), 32'd64);
    check("nom_err", 32'(err_cnt), 32'd0);
    check("nom_q", 32'(exp_q.size()), 32'd0);

    // Back-to-back mixed frame
    send_zeros(32);
    for (int i = 0; i < 64; i++) begin
      if (i == 5) begin
        push_exp(i, 5'h10, 8'h00, 8'h00, 8'h00);
        send_bits(32'hF0000000, 31, 0);
      end else begin
        push_exp(i, 5'h1F, 8'hAA, 8'h55, 8'h33);
        send_bits(32'hFFAA5533, 31, 0);
      end
    end
    send_zeros(64);
    check("b2b_done", 32'(done_cnt), 32'd2);
    check("b2b_pix", 32'(pix_seen), 32'd128);
    check("b2b_q", 32'(exp_q.size()), 32'd0);

    // Header error on word 3
    send_zeros(32);
    for (int i = 0; i < 3; i++) begin
      push_exp(i, 5'h10, 8'h0F, 8'h00, 8'h00);
      send_bits(32'hF00F0000, 31, 0);
    end
    send_bits(32'h700F0000, 31, 0);
    send_zeros(8);
    check("hdr_err", 32'(err_cnt), 32'd1);
    check("hdr_done", 32'(done_cnt), 32'd2);
    check("hdr_pix", 32'(pix_seen), 32'd131);
    check("hdr_busy", 32'(busy), 32'd0);

    // Clean frame after the error
    send_zeros(32);
    for (int i = 0; i < 64; i++) begin
      push_exp(i, 5'h1F, 8'hAA, 8'h55, 8'h33);
      send_bits(32'hFFAA5533, 31, 0);
    end
    send_zeros(64);
    check("clean_done", 32'(done_cnt), 32'd3);
    check("clean_pix", 32'(pix_seen), 32'd195);
    check("clean_q", 32'(exp_q.size()), 32'd0);

    // Timeout after 10 bits of word 7
    send_zeros(32);
    for (int i = 0; i < 7; i++) begin
      push_exp(i, 5'h1F, 8'hAA, 8'h55, 8'h33);
      send_bits(32'hFFAA5533, 31, 0);
    end
    send_bits(32'hFFAA5533, 31, 22);
    repeat (TIMEOUT + 5) @(negedge clk);
    check("to_err", 32'(err_cnt), 32'd2);
    check("to_busy", 32'(busy), 32'd0);
    check("to_pix", 32'(pix_seen), 32'd202);
`ifdef RX_ERR_CNT_EN
    check("to_err_count", 32'(err_count), 32'd2);
`endif

    // Reset in the middle of word 20, then resume without a start frame
    send_zeros(32);
    for (int i = 0; i < 20; i++) begin
      push_exp(i, 5'h1F, 8'hAA, 8'h55, 8'h33);
      send_bits(32'hFFAA5533, 31, 0);
    end
    send_bits(32'hFFAA5533, 31, 22);
    check("pre_rst_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("midrst");
    reset = 1'b0;
    send_bits(32'hFFAA5533, 21, 0);
    for (int i = 0; i < 10; i++) send_bits(32'hFFAA5533, 31, 0);
    repeat (10) @(negedge clk);
    check("rst_pix", 32'(pix_seen), 32'd222);
    check("rst_q", 32'(exp_q.size()), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done_cnt), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
